branch_predictor: RTL and testbench

Dynamic next-PC predictor for the fetch stage, replacing the purely resolved PC-source decision with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Fetch looks up the current PC combinationally. Execute returns the resolved outcome of every control-transfer instruction; the block trains its tables and raises a registered one-cycle mispredict/redirect pulse that the pipeline uses to flush. Branch semantics are MIPS with one delay slot.

---
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit direction counters.
// Fetch looks up if_pc combinationally. Execute resolutions train the
// table and raise a registered one-cycle redirect pulse.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [1:0]  ex_kind,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);
    localparam int DEPTH = 1 << INDEX_BITS;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_COND = 2'b01;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [1:0]          kind;
        logic [1:0]          cnt;
        logic [31:0]         target;
    } entry_t;

    entry_t tbl [DEPTH];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    entry_t                if_e, ex_e, wr_e;
    logic                  if_hit, ex_hit, wr_en, wrong;
    logic [31:0]           correct_pc;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign if_e   = tbl[if_idx];
    assign ex_e   = tbl[ex_idx];
    assign if_hit = if_e.valid && (if_e.tag == if_tag);
    assign ex_hit = ex_e.valid && (ex_e.tag == ex_tag);

    // Fetch-side prediction; unconditional jumps always predict taken on a hit
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = if_pc + 32'd4;
        if (if_hit) begin
            pred_taken = (if_e.kind == K_COND) ? if_e.cnt[1] : 1'b1;
            if (pred_taken) pred_target = if_e.target;
        end
    end

    // Judge the carried prediction and pick the correct fetch PC
    always_comb begin
        wrong = (ex_pred_taken != ex_taken) ||
                (ex_taken && (ex_pred_target != ex_target));
        if (ex_taken)              correct_pc = ex_target;
        else if (ex_kind == K_NONE) correct_pc = ex_pc + 32'd4;
        else                       correct_pc = ex_pc + 32'd8;   // skip delay slot
    end

    // Table write for this resolution: train on hit, allocate on taken miss,
    // invalidate an aliased entry that made a non-branch look taken
    always_comb begin
        wr_en = 1'b0;
        wr_e  = ex_e;
        if (ex_valid) begin
            if (ex_kind != K_NONE) begin
                if (ex_hit) begin
                    wr_en = 1'b1;
                    if (ex_kind == K_COND) begin
                        if (ex_taken) begin
                            wr_e.cnt    = (ex_e.cnt == 2'b11) ? 2'b11 : ex_e.cnt + 2'd1;
                            wr_e.target = ex_target;
                        end else begin
                            wr_e.cnt = (ex_e.cnt == 2'b00) ? 2'b00 : ex_e.cnt - 2'd1;
                        end
                    end else begin
                        wr_e.target = ex_target;
                    end
                end else if (ex_taken) begin
                    wr_en       = 1'b1;
                    wr_e.valid  = 1'b1;
                    wr_e.tag    = ex_tag;
                    wr_e.kind   = ex_kind;
                    wr_e.cnt    = 2'b10;
                    wr_e.target = ex_target;
                end
            end else if (ex_pred_taken && ex_hit) begin
                wr_en      = 1'b1;
                wr_e.valid = 1'b0;
            end
        end
    end

    // Table state; reset clears every entry and takes priority over writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, kind: 2'b00, cnt: 2'b01, target: 32'd0};
            end
        end else if (wr_en) begin
            tbl[ex_idx] <= wr_e;
        end
    end

    // Redirect pulse and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict  <= 1'b0;
            redirect_pc <= 32'd0;
            br_cnt      <= 32'd0;
            miss_cnt    <= 32'd0;
        end else begin
            mispredict <= ex_valid && wrong;
            if (ex_valid && wrong) begin
                redirect_pc <= correct_pc;
                miss_cnt    <= miss_cnt + 32'd1;
            end
            if (ex_valid && (ex_kind != K_NONE)) br_cnt <= br_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_kind;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_kind(ex_kind),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Combinational lookup check
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic t, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".target"}, pred_target, tgt);
    endtask

    // One resolution: drive at negedge, clock it in, sample after the edge
    task automatic resolve(input logic [31:0] pc, input logic [1:0] kind, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = pc; ex_kind = kind; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic outs(input string tag, input logic mp, input logic [31:0] rpc,
                        input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
        chk({tag, ".redirect_pc"}, redirect_pc, rpc);
        chk({tag, ".br_cnt"}, br_cnt, bc);
        chk({tag, ".miss_cnt"}, miss_cnt, mc);
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h0040_0100; ex_valid = 1'b0; ex_pc = '0; ex_kind = 2'b00;
        ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 1'b0, 32'h0, 32'd0, 32'd0);
        @(negedge clk); rst = 1'b0;
        look("reset_lookup", 32'h0040_0100, 1'b0, 32'h0040_0104);

        // First taken branch, predicted not taken: allocate and redirect
        resolve(32'h0040_0100, 2'b01, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0104);
        outs("first_taken", 1'b1, 32'h0040_0200, 32'd1, 32'd1);
        look("after_alloc", 32'h0040_0100, 1'b1, 32'h0040_0200);

        // Three correct taken resolutions saturate the counter at 11
        for (int i = 0; i < 3; i++)
            resolve(32'h0040_0100, 2'b01, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
        outs("taken_x3", 1'b0, 32'h0040_0200, 32'd4, 32'd1);

        // Not taken once: 11 -> 10, still predicts taken, redirect past delay slot
        resolve(32'h0040_0100, 2'b01, 1'b0, 32'h0040_0200, 1'b1, 32'h0040_0200);
        outs("nt_once", 1'b1, 32'h0040_0108, 32'd5, 32'd2);
        look("still_taken", 32'h0040_0100, 1'b1, 32'h0040_0200);
        @(negedge clk); @(posedge clk); #1;
        outs("hold_redirect", 1'b0, 32'h0040_0108, 32'd5, 32'd2);

        // Not taken again: 10 -> 01, now predicts not taken
        resolve(32'h0040_0100, 2'b01, 1'b0, 32'h0040_0200, 1'b1, 32'h0040_0200);
        outs("nt_twice", 1'b1, 32'h0040_0108, 32'd6, 32'd3);
        look("now_not_taken", 32'h0040_0100, 1'b0, 32'h0040_0104);

        // JR at 0x0040_0300 shares index 0 and replaces the branch entry
        resolve(32'h0040_0300, 2'b11, 1'b1, 32'h0040_1000, 1'b0, 32'h0040_0304);
        outs("jr_first", 1'b1, 32'h0040_1000, 32'd7, 32'd4);
        look("jr_lookup", 32'h0040_0300, 1'b1, 32'h0040_1000);
        look("jr_evicted", 32'h0040_0100, 1'b0, 32'h0040_0104);
        resolve(32'h0040_0300, 2'b11, 1'b1, 32'h0040_2000, 1'b1, 32'h0040_1000);
        outs("jr_stale", 1'b1, 32'h0040_2000, 32'd8, 32'd5);
        look("jr_retarget", 32'h0040_0300, 1'b1, 32'h0040_2000);

        // Alias at index 1: tag 0x05 then tag 0x06
        resolve(32'h0040_0504, 2'b01, 1'b1, 32'h0040_0800, 1'b0, 32'h0040_0508);
        outs("alias_a", 1'b1, 32'h0040_0800, 32'd9, 32'd6);
        look("alias_a_look", 32'h0040_0504, 1'b1, 32'h0040_0800);
        resolve(32'h0040_0604, 2'b01, 1'b1, 32'h0040_0900, 1'b0, 32'h0040_0608);
        outs("alias_b", 1'b1, 32'h0040_0900, 32'd10,32'd7);
        look("alias_b_look", 32'h0040_0604, 1'b1, 32'h0040_0900);
        look("alias_a_gone", 32'h0040_0504, 1'b0, 32'h0040_0508);
        // Non-branch predicted taken: invalidate, redirect to pc+4, br_cnt unchanged
        resolve(32'h0040_0604, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0040_0900);
        outs("kind00", 1'b1, 32'h0040_0608, 32'd10, 32'd8);
        look("kind00_inval", 32'h0040_0604, 1'b0, 32'h0040_0608);

        // Same-cycle write and lookup at one index: old contents before the edge
        @(negedge clk);
        if_pc = 32'h0040_0704;
        ex_valid = 1'b1; ex_pc = 32'h0040_0704; ex_kind = 2'b10; ex_taken = 1'b1;
        ex_target = 32'h0040_0a00; ex_pred_taken = 1'b1; ex_pred_target = 32'h0040_0a00;
        #1;
        chk("same_cycle.taken", {31'd0, pred_taken}, 32'd0);
        chk("same_cycle.target", pred_target, 32'h0040_0708);
        @(posedge clk); #1; ex_valid = 1'b0;
        outs("jal_correct", 1'b0, 32'h0040_0608, 32'd11, 32'd8);
        look("jal_lookup", 32'h0040_0704, 1'b1, 32'h0040_0a00);

        // Reset together with a resolution: reset wins
        @(negedge clk);
        rst = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h0040_0100; ex_kind = 2'b01; ex_taken = 1'b1;
        ex_target = 32'h0040_0c00; ex_pred_taken = 1'b0; ex_pred_target = 32'h0040_0104;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        outs("rst_wins", 1'b0, 32'h0, 32'd0, 32'd0);
        look("rst_no_alloc", 32'h0040_0100, 1'b0, 32'h0040_0104);
        look("rst_cleared", 32'h0040_0704, 1'b0, 32'h0040_0708);
        @(negedge clk); rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
